lsu_axi_bridge: RTL and testbench
=================================

LSU_AXI_BRIDGE -- requirements
Module: lsu_axi_bridge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address bus width in bits.
REQ-003 SHALL use one clock and asynchronous active-high reset, ports: ACLK  in  1  clock (rising edge); ARST  in  1  reset.
REQ-004 SHALL have core side ports:
- req_valid  in  1  load/store request
- req_ready  out  1  request accepted
- req_we  in  1  1=store, 0=load
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data
- req_wstrb  in  DATA_WIDTH/8  byte enables
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_WIDTH  load data
- resp_err  out  1  response not OKAY
- busy  out  1  transaction in flight
REQ-005 SHALL have AXI4-Lite master ports AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY as outputs, and AWREADY, WREADY, BVALID, BRESP[1:0], ARREADY, RVALID, RDATA, RRESP[1:0] as inputs, with widths per ADDR_WIDTH/DATA_WIDTH.

Function
REQ-006 SHALL implement FSM states IDLE, WRITE, WRESP, READ, RDATA; at most one transaction outstanding.
REQ-007 req_ready SHALL equal (state==IDLE); busy SHALL equal (state!=IDLE).
REQ-008 In IDLE, req_valid=1 and req_we=1 SHALL register addr/wdata/wstrb and go to WRITE next cycle.
REQ-009 In IDLE, req_valid=1 and req_we=0 SHALL register addr and go to READ next cycle.
REQ-010 AWADDR/ARADDR SHALL be the registered address with bits [1:0] forced to 0.
REQ-011 In WRITE, AWVALID and WVALID SHALL assert together; each SHALL deassert independently on its own handshake (VALID&READY at a clock edge) and never deassert before that handshake.
REQ-012 WRITE SHALL advance to WRESP on the edge where both AW and W have completed (same or different cycles); BREADY SHALL be 1 only in WRESP.
REQ-013 In WRESP, BVALID=1 SHALL return to IDLE and pulse resp_valid next cycle, resp_err=(BRESP!=2'b00), resp_rdata unchanged.
REQ-014 In READ, ARVALID SHALL be 1; ARVALID&ARREADY SHALL advance to RDATA; RREADY SHALL be 1 only in RDATA.
REQ-015 In RDATA, RVALID=1 SHALL capture RDATA into resp_rdata, set resp_err=(RRESP!=2'b00), pulse resp_valid next cycle, return to IDLE.
REQ-016 resp_valid SHALL be high exactly one cycle per transaction; a new request SHALL be acceptable in the cycle resp_valid is high.
REQ-017 AXI output payloads (AWADDR, WDATA, WSTRB, ARADDR) SHALL stay stable while their VALID is high.
REQ-018 BVALID or RVALID arriving in a state that does not expect them SHALL be ignored.
REQ-019 Minimum latency SHALL be: request accepted edge N, VALID high cycle N+1, resp_valid high cycle N+3 with zero-wait slave (write and read).

Reset
REQ-020 ARST=1 SHALL immediately force state=IDLE and all outputs low: AWVALID, WVALID, BREADY, ARVALID, RREADY, resp_valid, resp_err, busy=0; resp_rdata and AXI payloads=0; req_ready=1 after release.
REQ-021 Reset mid-transaction SHALL abandon it with no resp_valid pulse; first edge after release SHALL accept a new request.

Verification
REQ-022 Store addr=0x1003, wdata=0xDEADBEEF, wstrb=0xF, AWREADY/WREADY/BVALID always 1, BRESP=0 -> AWADDR=0x1000, resp_valid at N+3, resp_err=0.
REQ-023 Store with WREADY delayed 3 cycles after AWREADY -> AWVALID drops after its handshake, WVALID held with stable WDATA, single BREADY phase, one resp_valid.
REQ-024 Load addr=0x2000, ARREADY after 2 cycles, RDATA=0x12345678, RRESP=0 -> resp_rdata=0x12345678, resp_err=0, req_ready=0 until completion.
REQ-025 Load with RRESP=2'b10 (SLVERR) -> resp_valid=1, resp_err=1; next store with BRESP=0 -> resp_err=0.
REQ-026 Back-to-back store then load with req_valid held -> second request accepted in the resp_valid cycle, no overlapping VALIDs.
REQ-027 ARST asserted while in WRESP -> BREADY and busy drop immediately, no resp_valid; after release, new load completes normally.

Source files
------------

// File: rtl/lsu_axi_bridge_if.sv
// Bus bundle between a load/store unit and an AXI4-Lite slave.
// The master modport is the bridge's view; the slave modport is the environment's view.
interface lsu_axi_bridge_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_we;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic [DATA_WIDTH-1:0]     req_wdata;
    logic [DATA_WIDTH/8-1:0]   req_wstrb;
    logic                      resp_valid;
    logic [DATA_WIDTH-1:0]     resp_rdata;
    logic                      resp_err;
    logic                      busy;

    logic                      AWVALID;
    logic                      AWREADY;
    logic [ADDR_WIDTH-1:0]     AWADDR;
    logic                      WVALID;
    logic                      WREADY;
    logic [DATA_WIDTH-1:0]     WDATA;
    logic [DATA_WIDTH/8-1:0]   WSTRB;
    logic                      BVALID;
    logic                      BREADY;
    logic [1:0]                BRESP;
    logic                      ARVALID;
    logic                      ARREADY;
    logic [ADDR_WIDTH-1:0]     ARADDR;
    logic                      RVALID;
    logic                      RREADY;
    logic [DATA_WIDTH-1:0]     RDATA;
    logic [1:0]                RRESP;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output req_ready, resp_valid, resp_rdata, resp_err, busy,
        output AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
        input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy,
        input  AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
        output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );
endinterface

// File: rtl/lsu_axi_bridge.sv
// Load/store unit to AXI4-Lite master bridge with a single outstanding transaction.
//
// state | meaning
// IDLE  | ready for a core request
// WRITE | AW and W offered, each dropped on its own handshake
// WRESP | waiting for the write response
// READ  | AR offered
// RDATA | waiting for read data
module lsu_axi_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input logic              ACLK,
    input logic              ARST,
    lsu_axi_bridge_if.master bus
);
    typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA} state_t;

    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

    state_t                  state_q, state_d;
    logic                    aw_done_q, w_done_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] wstrb_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    err_q;
    logic                    resp_valid_q;
    logic                    aw_hs, w_hs, ar_hs;

    assign aw_hs = bus.AWVALID & bus.AWREADY;
    assign w_hs  = bus.WVALID & bus.WREADY;
    assign ar_hs = bus.ARVALID & bus.ARREADY;

    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req_valid) state_d = bus.req_we ? WRITE : READ;
            WRITE:   if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) state_d = WRESP;
            WRESP:   if (bus.BVALID) state_d = IDLE;
            READ:    if (ar_hs) state_d = RDATA;
            RDATA:   if (bus.RVALID) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Payloads only load in IDLE, so they cannot move while any VALID is up.
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q    <= bus.req_addr;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        if (bus.req_we) begin
                            wdata_q <= bus.req_wdata;
                            wstrb_q <= bus.req_wstrb;
                        end
                    end
                end
                WRITE: begin
                    if (aw_hs) aw_done_q <= 1'b1;
                    if (w_hs)  w_done_q  <= 1'b1;
                end
                WRESP: begin
                    if (bus.BVALID) begin
                        resp_valid_q <= 1'b1;
                        err_q        <= (bus.BRESP != 2'b00);
                    end
                end
                RDATA: begin
                    if (bus.RVALID) begin
                        resp_valid_q <= 1'b1;
                        rdata_q      <= bus.RDATA;
                        err_q        <= (bus.RRESP != 2'b00);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    assign bus.AWVALID = (state_q == WRITE) & ~aw_done_q;
    assign bus.WVALID  = (state_q == WRITE) & ~w_done_q;
    assign bus.BREADY  = (state_q == WRESP);
    assign bus.ARVALID = (state_q == READ);
    assign bus.RREADY  = (state_q == RDATA);
    assign bus.AWADDR  = addr_q & WORD_MASK;
    assign bus.ARADDR  = addr_q & WORD_MASK;
    assign bus.WDATA   = wdata_q;
    assign bus.WSTRB   = wstrb_q;
endmodule

// File: tb/tb_lsu_axi_bridge.sv
// Bench for lsu_axi_bridge: a transaction-level model with an AXI-Lite slave of
// configurable per-channel wait cycles, compared against the bridge every cycle.
module tb_lsu_axi_bridge;
    logic ACLK;
    logic ARST;

    lsu_axi_bridge_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
    lsu_axi_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (.ACLK(ACLK), .ARST(ARST), .bus(bus));

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        logic        err;
    } txn_t;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // slave configuration
    int          cfg_aw_dly = 0, cfg_w_dly = 0, cfg_ar_dly = 0, cfg_b_dly = 0, cfg_r_dly = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [31:0] cfg_rdata = 32'h0;
    bit          spur = 1'b0;

    // model state
    bit          active = 1'b0, resp_due = 1'b0;
    txn_t        act, exp_r;
    bit          aw_got, w_got, ar_got, b_pend, r_pend;
    int          aw_wait, w_wait, ar_wait, b_wait, r_wait;
    logic [31:0] last_rdata_m = 32'h0;
    int          acc_edge = 0, resp_cyc = 0, acc_count = 0;
    logic [31:0] last_awaddr = 32'h0, last_araddr = 32'h0;

    // observation counters
    int          cnt_awv, cnt_wv, cnt_bready, cnt_resp, cnt_notready;
    logic [31:0] last_resp_rdata;
    logic        last_resp_err;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic clear_model();
        aw_got = 0; w_got = 0; ar_got = 0; b_pend = 0; r_pend = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
    endtask

    task automatic complete();
        resp_due = 1'b1;
        exp_r    = act;
        if (!act.we) last_rdata_m = act.rdata;
        active   = 1'b0;
        resp_cyc = cyc + 1;
        clear_model();
    endtask

    // Model and slave: observe handshakes on the edge, then drive the slave 1ns later.
    always @(posedge ACLK) begin
        bit was_active;
        was_active = active;
        if (ARST) begin
            active = 1'b0; resp_due = 1'b0; last_rdata_m = 32'h0;
            clear_model();
        end else begin
            resp_due = 1'b0;
            if (was_active && act.we) begin
                if (bus.AWVALID && bus.AWREADY) begin aw_got = 1; last_awaddr = bus.AWADDR; end
                else if (bus.AWVALID) aw_wait++;
                if (bus.WVALID && bus.WREADY) w_got = 1;
                else if (bus.WVALID) w_wait++;
                if (b_pend && bus.BVALID && bus.BREADY) complete();
                else if (b_pend) b_wait++;
                if (active && aw_got && w_got && !b_pend) begin b_pend = 1; b_wait = 0; end
            end else if (was_active) begin
                if (r_pend && bus.RVALID && bus.RREADY) complete();
                else if (r_pend) r_wait++;
                if (active && bus.ARVALID && bus.ARREADY) begin
                    ar_got = 1; r_pend = 1; r_wait = 0; last_araddr = bus.ARADDR;
                end else if (bus.ARVALID) ar_wait++;
            end
            if (bus.req_valid && !was_active) begin
                active     = 1'b1;
                act.we     = bus.req_we;
                act.addr   = bus.req_addr;
                act.wdata  = bus.req_wdata;
                act.wstrb  = bus.req_wstrb;
                act.rdata  = bus.req_we ? last_rdata_m : cfg_rdata;
                act.err    = bus.req_we ? (cfg_bresp != 2'b00) : (cfg_rresp != 2'b00);
                acc_edge   = cyc;
                acc_count++;
                clear_model();
            end
        end
        cyc++;
        #1;
        if (ARST) begin
            bus.AWREADY = 0; bus.WREADY = 0; bus.ARREADY = 0; bus.BVALID = 0; bus.RVALID = 0;
            bus.BRESP = 2'b00; bus.RRESP = 2'b00; bus.RDATA = 32'h0;
        end else begin
            bus.AWREADY = (aw_wait >= cfg_aw_dly);
            bus.WREADY  = (w_wait >= cfg_w_dly);
            bus.ARREADY = (ar_wait >= cfg_ar_dly);
            bus.BVALID  = (b_pend && b_wait >= cfg_b_dly) || spur;
            bus.RVALID  = (r_pend && r_wait >= cfg_r_dly) || spur;
            bus.BRESP   = cfg_bresp;
            bus.RRESP   = cfg_rresp;
            bus.RDATA   = bus.RVALID ? cfg_rdata : 32'h0BAD_0BAD;
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge ACLK) begin
        if (ARST) begin
            chk("rst_awvalid", bus.AWVALID, 0);   chk("rst_wvalid", bus.WVALID, 0);
            chk("rst_bready", bus.BREADY, 0);     chk("rst_arvalid", bus.ARVALID, 0);
            chk("rst_rready", bus.RREADY, 0);     chk("rst_resp_valid", bus.resp_valid, 0);
            chk("rst_resp_err", bus.resp_err, 0); chk("rst_busy", bus.busy, 0);
            chk("rst_resp_rdata", bus.resp_rdata, 0);
            chk("rst_awaddr", bus.AWADDR, 0);     chk("rst_araddr", bus.ARADDR, 0);
            chk("rst_wdata", bus.WDATA, 0);       chk("rst_wstrb", bus.WSTRB, 0);
        end else begin
            bit e_aw, e_w, e_b, e_ar, e_r;
            e_aw = active && act.we && !aw_got;
            e_w  = active && act.we && !w_got;
            e_b  = active && act.we && aw_got && w_got;
            e_ar = active && !act.we && !ar_got;
            e_r  = active && !act.we && ar_got;
            chk("busy", bus.busy, active);
            chk("req_ready", bus.req_ready, !active);
            chk("awvalid", bus.AWVALID, e_aw);
            chk("wvalid", bus.WVALID, e_w);
            chk("bready", bus.BREADY, e_b);
            chk("arvalid", bus.ARVALID, e_ar);
            chk("rready", bus.RREADY, e_r);
            chk("no_rw_overlap", bus.ARVALID && (bus.AWVALID || bus.WVALID), 0);
            if (e_aw) chk("awaddr", bus.AWADDR, {act.addr[31:2], 2'b00});
            if (e_w) begin
                chk("wdata", bus.WDATA, act.wdata);
                chk("wstrb", bus.WSTRB, act.wstrb);
            end
            if (e_ar) chk("araddr", bus.ARADDR, {act.addr[31:2], 2'b00});
            chk("resp_valid", bus.resp_valid, resp_due);
            if (resp_due) begin
                chk("resp_rdata", bus.resp_rdata, exp_r.rdata);
                chk("resp_err", bus.resp_err, exp_r.err);
            end
        end
        cnt_awv      += int'(bus.AWVALID);
        cnt_wv       += int'(bus.WVALID);
        cnt_bready   += int'(bus.BREADY);
        cnt_resp     += int'(bus.resp_valid);
        cnt_notready += int'(!bus.req_ready);
        if (bus.resp_valid) begin
            last_resp_rdata = bus.resp_rdata;
            last_resp_err   = bus.resp_err;
        end
    end

    task automatic clr_cnt();
        cnt_awv = 0; cnt_wv = 0; cnt_bready = 0; cnt_resp = 0; cnt_notready = 0;
    endtask

    task automatic set_dly(input int aw, input int w, input int ar, input int b, input int r);
        cfg_aw_dly = aw; cfg_w_dly = w; cfg_ar_dly = ar; cfg_b_dly = b; cfg_r_dly = r;
    endtask

    // Called at posedge+2; returns at posedge+2 of the accepting edge.
    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input bit hold);
        int start;
        int t;
        start = acc_count;
        t = 0;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a; bus.req_wdata = d; bus.req_wstrb = s;
        while (acc_count == start && t < 50) begin
            @(posedge ACLK); #2;
            t++;
        end
        if (acc_count == start) chk("issue_timeout", 1, 0);
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while ((active || resp_due) && t < 100) begin
            @(posedge ACLK); #2;
            t++;
        end
        if (t >= 100) chk("done_timeout", 1, 0);
        @(posedge ACLK); #2;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw, w, ar, b, r;
        logic [1:0]  bresp, rresp;
        logic [31:0] rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[4];

    initial begin
        ARST = 1'b1;
        bus.req_valid = 0; bus.req_we = 0; bus.req_addr = 0; bus.req_wdata = 0; bus.req_wstrb = 0;
        clr_cnt();
        repeat (3) @(posedge ACLK);
        #2 ARST = 1'b0;
        #1;
        chk("release_req_ready", bus.req_ready, 1);
        chk("release_busy", bus.busy, 0);
        @(posedge ACLK); #2;

        // zero-wait store, sub-word address
        set_dly(0, 0, 0, 0, 0); cfg_bresp = 2'b00;
        clr_cnt();
        issue(1, 32'h0000_1003, 32'hDEAD_BEEF, 4'hF, 0);
        wait_done();
        chk("st0_awaddr", last_awaddr, 32'h0000_1000);
        chk("st0_latency", resp_cyc - acc_edge, 3);
        chk("st0_err", last_resp_err, 0);
        chk("st0_resp_count", cnt_resp, 1);

        // W accepted three cycles after AW
        set_dly(0, 3, 0, 0, 0);
        clr_cnt();
        issue(1, 32'h0000_3008, 32'hA5A5_0F0F, 4'b0101, 0);
        wait_done();
        chk("wdly_latency", resp_cyc - acc_edge, 6);
        chk("wdly_awvalid_cycles", cnt_awv, 1);
        chk("wdly_wvalid_cycles", cnt_wv, 4);
        chk("wdly_bready_cycles", cnt_bready, 1);
        chk("wdly_resp_count", cnt_resp, 1);

        // AW accepted late, B one cycle late
        set_dly(2, 0, 0, 1, 0);
        clr_cnt();
        issue(1, 32'h0000_4000, 32'h0000_0000, 4'h0, 0);
        wait_done();
        chk("awdly_latency", resp_cyc - acc_edge, 6);
        chk("awdly_awvalid_cycles", cnt_awv, 3);
        chk("awdly_wvalid_cycles", cnt_wv, 1);
        chk("awdly_bready_cycles", cnt_bready, 2);

        // load with ARREADY after 2 cycles
        set_dly(0, 0, 2, 0, 0); cfg_rresp = 2'b00; cfg_rdata = 32'h1234_5678;
        clr_cnt();
        issue(0, 32'h0000_2000, 32'h0, 4'h0, 0);
        wait_done();
        chk("ld0_araddr", last_araddr, 32'h0000_2000);
        chk("ld0_rdata", last_resp_rdata, 32'h1234_5678);
        chk("ld0_err", last_resp_err, 0);
        chk("ld0_latency", resp_cyc - acc_edge, 5);
        chk("ld0_notready_cycles", cnt_notready, 4);

        // SLVERR load, then clean store keeps the load data
        set_dly(0, 0, 0, 0, 0); cfg_rresp = 2'b10; cfg_rdata = 32'hCAFE_F00D;
        clr_cnt();
        issue(0, 32'h0000_2006, 32'h0, 4'h0, 0);
        wait_done();
        chk("slverr_err", last_resp_err, 1);
        chk("slverr_resp_count", cnt_resp, 1);
        chk("slverr_latency", resp_cyc - acc_edge, 3);
        cfg_rresp = 2'b00; cfg_bresp = 2'b00;
        issue(1, 32'h0000_5000, 32'h0102_0304, 4'h3, 0);
        wait_done();
        chk("after_err_store_err", last_resp_err, 0);
        chk("after_err_store_rdata", last_resp_rdata, 32'hCAFE_F00D);

        // stray B/R while idle must be ignored
        clr_cnt();
        spur = 1'b1;
        repeat (3) begin @(posedge ACLK); #2; end
        spur = 1'b0;
        repeat (2) begin @(posedge ACLK); #2; end
        chk("stray_resp_count", cnt_resp, 0);
        chk("stray_busy", bus.busy, 0);

        // mixed table
        vecs[0] = '{1, 32'h0000_8001, 32'h1111_2222, 4'hC, 1, 1, 0, 2, 0, 2'b11, 2'b00, 32'h0, 1};
        vecs[1] = '{0, 32'h0000_8102, 32'h0, 4'h0, 0, 0, 1, 0, 3, 2'b00, 2'b01, 32'h7777_8888, 1};
        vecs[2] = '{0, 32'h0000_8200, 32'h0, 4'h0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 32'h9ABC_DEF0, 0};
        vecs[3] = '{1, 32'hFFFF_FFFF, 32'h5555_AAAA, 4'h9, 3, 2, 0, 0, 0, 2'b00, 2'b00, 32'h0, 0};
        foreach (vecs[i]) begin
            set_dly(vecs[i].aw, vecs[i].w, vecs[i].ar, vecs[i].b, vecs[i].r);
            cfg_bresp = vecs[i].bresp; cfg_rresp = vecs[i].rresp; cfg_rdata = vecs[i].rdata;
            clr_cnt();
            issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, 0);
            wait_done();
            chk("vec_err", last_resp_err, vecs[i].exp_err);
            chk("vec_resp_count", cnt_resp, 1);
        end
        chk("vec_last_rdata", last_resp_rdata, 32'h9ABC_DEF0);

        // back-to-back store then load with req_valid held
        set_dly(0, 0, 0, 0, 0); cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_rdata = 32'h0F0F_1234;
        clr_cnt();
        issue(1, 32'h0000_6000, 32'h1122_3344, 4'hF, 1);
        issue(0, 32'h0000_6010, 32'h0, 4'h0, 0);
        chk("b2b_accept_in_resp_cycle", acc_edge, resp_cyc);
        wait_done();
        chk("b2b_load_latency", resp_cyc - acc_edge, 3);
        chk("b2b_rdata", last_resp_rdata, 32'h0F0F_1234);
        chk("b2b_resp_count", cnt_resp, 2);

        // reset while waiting for B
        set_dly(0, 0, 0, 5, 0);
        clr_cnt();
        issue(1, 32'h0000_7000, 32'hFEED_FACE, 4'hF, 0);
        begin
            int t;
            t = 0;
            while (!bus.BREADY && t < 20) begin @(posedge ACLK); #2; t++; end
            chk("wresp_reached", bus.BREADY, 1);
        end
        ARST = 1'b1;
        #1;
        chk("midrst_bready", bus.BREADY, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_resp_valid", bus.resp_valid, 0);
        repeat (2) begin @(posedge ACLK); #2; end
        set_dly(0, 0, 0, 0, 0); cfg_rdata = 32'h55AA_55AA; cfg_rresp = 2'b00;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h0000_7004;
        begin
            int start;
            int rel_edge;
            start = acc_count;
            ARST = 1'b0;
            rel_edge = cyc;
            @(posedge ACLK); #2;
            chk("post_rst_accept", acc_count - start, 1);
            chk("post_rst_accept_edge", acc_edge, rel_edge);
        end
        bus.req_valid = 1'b0;
        wait_done();
        chk("post_rst_rdata", last_resp_rdata, 32'h55AA_55AA);
        chk("post_rst_err", last_resp_err, 0);
        chk("post_rst_resp_count", cnt_resp, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish, limit 200000 ns");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end
endmodule
